// File: rtl/cpu_types_pkg.sv
// Shared types for the branch prediction unit: control-flow kinds, predictor modes
// and the BTB entry layout.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    KindNone   = 2'b00,
    KindBranch = 2'b01,
    KindJump   = 2'b10,
    KindRsvd   = 2'b11
  } upd_kind_e;

  localparam int unsigned ModeStatic = 0;
  localparam int unsigned ModeOneBit = 1;
  localparam int unsigned ModeTwoBit = 2;

  localparam logic [1:0] CtrReset = 2'b01;
  localparam logic [1:0] CtrAlloc = 2'b10;

  // Tag is sized for the smallest BTB; unused upper bits stay zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    logic        is_jump;
    logic [1:0]  ctr;
  } btb_entry_t;

  localparam btb_entry_t EntryReset = '{
    valid:   1'b0,
    tag:     30'd0,
    target:  30'd0,
    is_jump: 1'b0,
    ctr:     CtrReset
  };

  function automatic logic is_ctrl_kind(logic [1:0] kind);
    return (kind == KindBranch) || (kind == KindJump);
  endfunction

endpackage

// File: rtl/sat_counter2.sv
// Next-state logic for the per-entry 2-bit direction counter, covering both
// the saturating (MODE 2) and last-outcome (MODE 1) policies.
module sat_counter2
  import cpu_types_pkg::*;
#(
  parameter int unsigned MODE = ModeTwoBit
) (
  input  logic [1:0] ctr,
  input  logic       taken,
  input  logic       alloc,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (MODE == ModeOneBit) begin
      ctr_next = taken ? 2'b11 : 2'b00;
    end else if (alloc) begin
      ctr_next = CtrAlloc;
    end else if (taken) begin
      if (ctr != 2'b11) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != 2'b00) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with per-entry direction counters: combinational fetch-stage
// lookup, memory-stage resolution/update and saturating statistics.
module branch_predict_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned ENTRIES = 16,
  parameter int unsigned MODE    = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [31:0]       fetch_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [31:0]       pred_target,
  input  logic              upd_valid,
  input  logic [31:0]       upd_pc,
  input  logic [31:0]       upd_target,
  input  logic [1:0]        upd_kind,
  input  logic              upd_taken,
  input  logic              upd_pred_taken,
  input  logic [31:0]       upd_pred_target,
  output logic              btb_correct,
  output logic              btb_wrongtype,
  output logic [STAT_W-1:0] lookups,
  output logic [STAT_W-1:0] mispredicts
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);

  btb_entry_t btb_q [ENTRIES];

  logic [IDX_W-1:0]  fetch_idx, upd_idx;
  logic [29:0]       fetch_tag, upd_tag;
  btb_entry_t        fetch_e, upd_e, wr_entry;
  logic              upd_hit, wr_en;
  logic              is_branch, is_jump, target_ok;
  logic [1:0]        ctr_next;
  logic [STAT_W-1:0] lookups_q, mispredicts_q;
  logic              unused_bits;

  assign unused_bits = ^{fetch_pc[1:0], upd_pc[1:0], upd_target[1:0]};

  // Lookup
  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = {{IDX_W{1'b0}}, fetch_pc[31:IDX_W+2]};
  assign fetch_e   = btb_q[fetch_idx];

  assign pred_hit    = fetch_e.valid && (fetch_e.tag == fetch_tag);
  assign pred_taken  = (MODE != ModeStatic) && pred_hit && (fetch_e.is_jump || fetch_e.ctr[1]);
  assign pred_target = pred_taken ? {fetch_e.target, 2'b00} : fetch_pc + 32'd4;

  // Resolution
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = {{IDX_W{1'b0}}, upd_pc[31:IDX_W+2]};
  assign upd_e   = btb_q[upd_idx];
  assign upd_hit = upd_e.valid && (upd_e.tag == upd_tag);

  assign is_branch = (upd_kind == KindBranch);
  assign is_jump   = (upd_kind == KindJump);
  assign target_ok = !upd_taken || (upd_pred_target == upd_target);

  assign btb_wrongtype = upd_valid && upd_pred_taken && !is_ctrl_kind(upd_kind);
  assign btb_correct   = !upd_valid ||
                         (!btb_wrongtype && (upd_pred_taken == upd_taken) && target_ok);

  sat_counter2 #(
    .MODE (MODE)
  ) u_ctr (
    .ctr      (upd_e.ctr),
    .taken    (upd_taken),
    .alloc    (!upd_hit),
    .ctr_next (ctr_next)
  );

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = upd_e;
    if ((MODE != ModeStatic) && upd_valid) begin
      if (btb_wrongtype) begin
        // A non-control instruction was predicted taken: drop its stale entry.
        if (upd_hit) begin
          wr_en          = 1'b1;
          wr_entry.valid = 1'b0;
        end
      end else if (is_branch || is_jump) begin
        if (upd_hit) begin
          wr_en            = 1'b1;
          wr_entry.is_jump = is_jump;
          if (is_branch) wr_entry.ctr = ctr_next;
          if (upd_taken) wr_entry.target = upd_target[31:2];
        end else if (upd_taken) begin
          wr_en    = 1'b1;
          wr_entry = '{
            valid:   1'b1,
            tag:     upd_tag,
            target:  upd_target[31:2],
            is_jump: is_jump,
            ctr:     ctr_next
          };
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= EntryReset;
      end
    end else if (wr_en) begin
      btb_q[upd_idx] <= wr_entry;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      if (lookups_q != '1) lookups_q <= lookups_q + STAT_W'(1);
      if (upd_valid && !btb_correct && (mispredicts_q != '1)) begin
        mispredicts_q <= mispredicts_q + STAT_W'(1);
      end
    end
  end

  assign lookups     = lookups_q;
  assign mispredicts = mispredicts_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench: the driver queues expected outputs, a negedge monitor compares them.
module tb_branch_predict_unit;

  localparam logic [1:0] KN = 2'b00, KB = 2'b01, KJ = 2'b10, KR = 2'b11;
  localparam int SHit = 0, STkn = 1, STgt = 2, SCor = 3, SWt = 4, SLk = 5, SMp = 6;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] target;
    logic [1:0]  kind;
    logic        taken;
    logic        ptaken;
    logic [31:0] ptarget;
  } upd_t;

  typedef struct {
    int          dut;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        nrst [2];
  logic [31:0] fetch_pc [2];
  upd_t        u [2];
  logic        pred_hit [2], pred_taken [2], btb_correct [2], btb_wrongtype [2];
  logic [31:0] pred_target [2];
  logic [15:0] lookups [2], mispredicts [2];

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   lk_a = 0;

  branch_predict_unit #(.ENTRIES(16), .MODE(2), .STAT_W(16)) dut_a (
    .CLK (clk), .nRST (nrst[0]), .fetch_pc (fetch_pc[0]),
    .pred_hit (pred_hit[0]), .pred_taken (pred_taken[0]), .pred_target (pred_target[0]),
    .upd_valid (u[0].valid), .upd_pc (u[0].pc), .upd_target (u[0].target),
    .upd_kind (u[0].kind), .upd_taken (u[0].taken), .upd_pred_taken (u[0].ptaken),
    .upd_pred_target (u[0].ptarget), .btb_correct (btb_correct[0]),
    .btb_wrongtype (btb_wrongtype[0]), .lookups (lookups[0]), .mispredicts (mispredicts[0])
  );

  branch_predict_unit #(.ENTRIES(16), .MODE(0), .STAT_W(16)) dut_b (
    .CLK (clk), .nRST (nrst[1]), .fetch_pc (fetch_pc[1]),
    .pred_hit (pred_hit[1]), .pred_taken (pred_taken[1]), .pred_target (pred_target[1]),
    .upd_valid (u[1].valid), .upd_pc (u[1].pc), .upd_target (u[1].target),
    .upd_kind (u[1].kind), .upd_taken (u[1].taken), .upd_pred_taken (u[1].ptaken),
    .upd_pred_target (u[1].ptarget), .btb_correct (btb_correct[1]),
    .btb_wrongtype (btb_wrongtype[1]), .lookups (lookups[1]), .mispredicts (mispredicts[1])
  );

  function automatic logic [31:0] sample(input int d, input int s);
    logic [31:0] r;
    r = '0;
    case (s)
      SHit:    r = {31'd0, pred_hit[d]};
      STkn:    r = {31'd0, pred_taken[d]};
      STgt:    r = pred_target[d];
      SCor:    r = {31'd0, btb_correct[d]};
      SWt:     r = {31'd0, btb_wrongtype[d]};
      SLk:     r = {16'd0, lookups[d]};
      default: r = {16'd0, mispredicts[d]};
    endcase
    return r;
  endfunction

  // Monitor: outputs are combinational, so every queued expectation is due this cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      act = sample(e.dut, e.sel);
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: dut%0d got 0x%0h expected 0x%0h", e.name, e.dut, act, e.val);
      end
    end
  end

  task automatic chk(input int d, input int s, input logic [31:0] v, input string n);
    exp_t e;
    e.dut = d; e.sel = s; e.val = v; e.name = n;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    if (nrst[0]) lk_a++;
    #1;
  endtask

  task automatic drive(input int d, input logic [31:0] pc, input logic [1:0] kind,
                       input logic taken, input logic [31:0] tgt,
                       input logic pt, input logic [31:0] ptg);
    u[d] = '{valid: 1'b1, pc: pc, target: tgt, kind: kind, taken: taken,
             ptaken: pt, ptarget: ptg};
  endtask

  task automatic idle(input int d);
    u[d].valid = 1'b0;
  endtask

  initial begin
    nrst[0] = 1'b0; nrst[1] = 1'b0;
    fetch_pc[0] = 32'h40; fetch_pc[1] = 32'h40;
    u[0] = '0; u[1] = '0;

    // Reset state
    step();
    chk(0, SHit, 0, "rst_hit");        chk(0, STkn, 0, "rst_taken");
    chk(0, STgt, 32'h44, "rst_target"); chk(0, SCor, 1, "rst_correct");
    chk(0, SLk, 0, "rst_lookups");     chk(0, SMp, 0, "rst_mispredicts");
    step();
    nrst[0] = 1'b1; lk_a = 0;
    chk(0, SLk, 0, "lookups_start");   chk(0, SHit, 0, "miss_after_release");

    // Allocate BEQ 0x40 -> 0x80
    drive(0, 32'h40, KB, 1, 32'h80, 0, 32'h44);
    chk(0, SCor, 0, "alloc_mispredict"); chk(0, SWt, 0, "alloc_wrongtype");
    chk(0, SHit, 0, "alloc_no_bypass");
    step(); idle(0);
    chk(0, SHit, 1, "hit_after_alloc");  chk(0, STkn, 1, "taken_after_alloc");
    chk(0, STgt, 32'h80, "target_after_alloc"); chk(0, SMp, 1, "mp_after_alloc");
    chk(0, SLk, 32'(lk_a), "lookups_running");

    // Counter walks down and saturates at 00, then back up
    drive(0, 32'h40, KB, 0, 32'h80, 1, 32'h80);
    chk(0, SCor, 0, "nt_mispredict");
    step(); idle(0);
    chk(0, SHit, 1, "ctr01_hit"); chk(0, STkn, 0, "ctr01_not_taken");
    chk(0, STgt, 32'h44, "ctr01_fallthrough"); chk(0, SMp, 2, "mp_after_nt");
    drive(0, 32'h40, KB, 0, 32'h80, 0, 32'h44);
    chk(0, SCor, 1, "nt_correct");
    step(); step();
    drive(0, 32'h40, KB, 1, 32'h80, 1, 32'h80);
    step(); idle(0);
    chk(0, STkn, 0, "sat_low_01");
    drive(0, 32'h40, KB, 1, 32'h80, 1, 32'h80);
    step(); idle(0);
    chk(0, STkn, 1, "sat_low_10");
    drive(0, 32'h40, KB, 1, 32'h80, 1, 32'h80);
    step(); step();
    drive(0, 32'h40, KB, 0, 32'h80, 0, 32'h44);
    step(); idle(0);
    chk(0, STkn, 1, "sat_high_10"); chk(0, SMp, 2, "mp_correct_run");

    // Target change on hit
    drive(0, 32'h40, KB, 1, 32'hC0, 1, 32'h80);
    chk(0, SCor, 0, "target_mismatch"); chk(0, STgt, 32'h80, "no_bypass_target");
    step(); idle(0);
    chk(0, STgt, 32'hC0, "target_rewritten"); chk(0, SMp, 3, "mp_target");

    // Alias: 0x80 shares index 0 with 0x40
    drive(0, 32'h80, KJ, 1, 32'h200, 0, 32'h84);
    step(); idle(0);
    chk(0, SHit, 0, "alias_old_miss"); chk(0, SMp, 4, "mp_alias");
    step();
    fetch_pc[0] = 32'h80;
    chk(0, SHit, 1, "alias_new_hit"); chk(0, STkn, 1, "jump_taken");
    chk(0, STgt, 32'h200, "jump_target");

    // Wrongtype invalidates; reserved kind behaves as not-control
    drive(0, 32'h80, KN, 0, 32'h84, 1, 32'h200);
    chk(0, SWt, 1, "wt_none"); chk(0, SCor, 0, "wt_none_incorrect");
    step(); idle(0);
    chk(0, SHit, 0, "wt_invalidated"); chk(0, SMp, 5, "mp_wt");
    drive(0, 32'h300, KR, 1, 32'h400, 1, 32'h400);
    chk(0, SWt, 1, "wt_rsvd"); chk(0, SCor, 0, "wt_forces_incorrect");
    step(); idle(0);
    chk(0, SMp, 6, "mp_wt_rsvd");

    // Not-taken miss does not allocate
    fetch_pc[0] = 32'h100;
    drive(0, 32'h100, KB, 0, 32'h180, 0, 32'h104);
    chk(0, SCor, 1, "nt_miss_correct");
    step(); idle(0);
    chk(0, SHit, 0, "nt_miss_no_alloc");

    // Asynchronous reset with a pending update
    fetch_pc[0] = 32'h140;
    drive(0, 32'h140, KB, 1, 32'h240, 0, 32'h144);
    step(); idle(0);
    chk(0, SHit, 1, "pre_reset_hit"); chk(0, SMp, 7, "pre_reset_mp");
    step();
    nrst[0] = 1'b0;
    chk(0, SHit, 0, "async_reset_hit"); chk(0, SLk, 0, "async_reset_lookups");
    chk(0, SMp, 0, "async_reset_mp");
    fetch_pc[0] = 32'h180;
    drive(0, 32'h180, KB, 1, 32'h300, 0, 32'h184);
    step();
    nrst[0] = 1'b1; lk_a = 0;
    chk(0, SHit, 0, "update_discarded"); chk(0, SLk, 0, "lookups_restart");
    step(); idle(0);
    chk(0, SHit, 1, "first_update_accepted"); chk(0, STgt, 32'h300, "first_update_target");
    chk(0, SLk, 1, "lookups_one"); chk(0, SMp, 1, "mp_after_restart");

    // MODE 0: never predicts taken, never writes, still reports mispredicts
    nrst[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'h40, KB, 1, 32'h80, 0, 32'h44);
      chk(1, STkn, 0, "static_not_taken");
      if (i == 0) begin
        chk(1, SCor, 0, "static_incorrect"); chk(1, SWt, 0, "static_wrongtype");
      end
      step();
    end
    idle(1);
    chk(1, SHit, 0, "static_no_alloc"); chk(1, SMp, 10, "static_mp_ten");
    drive(1, 32'h40, KN, 0, 32'h44, 1, 32'h80);
    chk(1, SWt, 1, "static_wt"); chk(1, SCor, 0, "static_wt_incorrect");
    step();
    drive(1, 32'h40, KB, 1, 32'h80, 0, 32'h44);
    repeat (65535 - 11) step();
    idle(1);
    chk(1, SMp, 32'hFFFF, "mp_at_max");
    drive(1, 32'h40, KB, 1, 32'h80, 0, 32'h44);
    step(); idle(1);
    chk(1, SMp, 32'hFFFF, "mp_saturated"); chk(1, SLk, 32'hFFFF, "lookups_saturated");

    step(); step();
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

Interface
REQ-001 SHALL have parameter ENTRIES, default 16, meaning BTB depth; power of two, 2..256.
REQ-002 SHALL have parameter MODE, default 2, meaning 0 = static not-taken, 1 = one-bit history, 2 = two-bit saturating counter.
REQ-003 SHALL have parameter STAT_W, default 16, meaning statistics counter width.
REQ-004 SHALL have port CLK  input  1  system clock; one clock, all state on its rising edge.
REQ-005 SHALL have port nRST  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port fetch_pc  input  32  PC being fetched.
REQ-007 SHALL have ports pred_hit, pred_taken  output  1 each, and pred_target  output  32; together these form the fetch-stage prediction.
REQ-008 SHALL have port upd_valid  input  1  resolved control-flow info present from the memory stage.
REQ-009 SHALL have ports upd_pc, upd_target  input  32 each  resolved instruction PC and actual target.
REQ-010 SHALL have port upd_kind  input  2  00 = not control, 01 = conditional branch (BEQ/BNE), 10 = jump (J/JAL), 11 = reserved, treated as 00.
REQ-011 SHALL have ports upd_taken  input  1  actual outcome; upd_pred_taken  input  1, upd_pred_target  input  32  the prediction carried down the pipe.
REQ-012 SHALL have ports btb_correct, btb_wrongtype  output  1 each  consumed by the control unit for pc_sel 100/101 selection.
REQ-013 SHALL have ports lookups, mispredicts  output  STAT_W each  statistics.

Function
REQ-014 Index SHALL be pc[IDX_W+1:2] with IDX_W = log2(ENTRIES); tag SHALL be pc[31:IDX_W+2].
REQ-015 Each entry SHALL hold valid, tag, 30-bit word target, kind bit (branch/jump) and a 2-bit counter.
REQ-016 Lookup SHALL be combinational: pred_hit = valid and tag match; pred_taken = pred_hit and (kind = jump or counter[1]); pred_target = stored target, or fetch_pc+4 when not taken.
REQ-017 btb_correct SHALL be 1 when upd_valid = 0; otherwise 1 iff upd_pred_taken = upd_taken and (upd_taken = 0 or upd_pred_target = upd_target).
REQ-018 btb_wrongtype SHALL be upd_valid and upd_pred_taken and upd_kind in {00,11}; btb_wrongtype = 1 SHALL force btb_correct = 0.
REQ-019 Updates SHALL occur on the clock edge in the cycle upd_valid = 1: taken with miss allocates (counter 10, kind from upd_kind); hit branch increments on taken, decrements on not-taken, saturating at 11/00; not-taken miss does not allocate; hit with changed target rewrites the target.
REQ-020 MODE 1: taken SHALL write counter 11, not-taken SHALL write 00.
REQ-021 MODE 0: pred_taken SHALL be 0, and no entry writes SHALL occur; REQ-017/018 SHALL still apply.
REQ-022 Wrongtype SHALL invalidate the entry matching upd_pc.
REQ-023 Same-cycle lookup and update of one index SHALL return pre-update contents (no bypass).
REQ-024 lookups SHALL increment each cycle nRST is high; mispredicts SHALL increment when upd_valid and !btb_correct; both SHALL saturate at all-ones.

Reset
REQ-025 nRST low SHALL asynchronously clear all valid bits, counters to 01, targets/tags to 0, statistics to 0; outputs SHALL read pred_hit = 0, pred_taken = 0, pred_target = fetch_pc+4, btb_correct = 1 when upd_valid = 0.
REQ-026 Reset during a pending update SHALL discard it; the first update SHALL be accepted on the first edge after release.

Structure
REQ-027 upd_kind encoding, MODE constants and a btb_entry_t typedef SHALL live in cpu_types_pkg.
REQ-028 The 2-bit counter next-state logic SHALL be one sub-module, sat_counter2, which also implements MODE 1.

Verification
REQ-029 Reset, fetch_pc = 0x40 -> pred_hit = 0, pred_target = 0x44, lookups counts from 0.
REQ-030 Update pc 0x40 BEQ taken to 0x80, then fetch 0x40 -> hit, taken, target 0x80; two not-taken updates -> counter 00, pred_taken = 0.
REQ-031 ENTRIES = 16: update pc 0x40 then 0x80 (same index) -> 0x40 misses, 0x80 hits.
REQ-032 upd_pred_taken = 1, upd_kind = 00 -> btb_wrongtype = 1, btb_correct = 0, entry invalidated, mispredicts +1.
REQ-033 MODE 0, ten taken updates -> pred_taken stays 0; mispredicts = 10.
REQ-034 Force mispredicts to STAT_W'hFFFF, one more mispredict -> value holds at 0xFFFF.
